// File: rtl/fp_pkg.sv
// Shared constants, operand classification and field helpers for the
// parametrised floating-point units of the CORDIC datapath.
package fp_pkg;

  localparam int EXP_SIZE      = 8;
  localparam int MANTISSA_SIZE = 7;
  localparam int BIAS          = (1 << (EXP_SIZE - 1)) - 1;
  localparam int EXP_MAX       = (1 << EXP_SIZE) - 1;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Helpers take the field widths as arguments so any parametrisation can use them.
  function automatic logic [63:0] fp_exp(input logic [63:0] x, input int es, input int ms);
    return (x >> ms) & ((64'd1 << es) - 64'd1);
  endfunction

  function automatic logic [63:0] fp_frac(input logic [63:0] x, input int ms);
    return x & ((64'd1 << ms) - 64'd1);
  endfunction

  function automatic logic fp_sign(input logic [63:0] x, input int es, input int ms);
    return x[es + ms];
  endfunction

  function automatic logic [63:0] fp_qnan(input int es, input int ms);
    return (((64'd1 << es) - 64'd1) << ms) | (64'd1 << (ms - 1));
  endfunction

  function automatic fp_class_e fp_classify(input logic [63:0] e, input logic [63:0] f,
                                            input int es);
    if (e == 64'd0)                         return FP_ZERO;
    else if (e == ((64'd1 << es) - 64'd1))  return (f == 64'd0) ? FP_INF : FP_NAN;
    else                                    return FP_NORM;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; o_count = W and o_zero = 1 for an all-zero input.
module fp_lzc #(
  parameter int W  = 11,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_count,
  output logic          o_zero
);

  // Scanning upward lets the most significant set bit win.
  always_comb begin
    o_count = CW'(W);
    o_zero  = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (i_data[i]) begin
        o_count = CW'(W - 1 - i);
        o_zero  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Four-stage floating-point add/subtract: align, add, normalise, round/pack,
// with special values resolved up front and carried alongside as a bypass.
module fp_addsub_pipe #(
  parameter int  EXP_SIZE      = fp_pkg::EXP_SIZE,
  parameter int  MANTISSA_SIZE = fp_pkg::MANTISSA_SIZE,
  localparam int WIDTH         = 1 + EXP_SIZE + MANTISSA_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags
);
  import fp_pkg::*;

  localparam int ES    = EXP_SIZE;
  localparam int MS    = MANTISSA_SIZE;
  localparam int EW    = ES + 2;
  localparam int MW    = MS + 4;
  localparam int SW    = MS + 5;
  localparam int CW    = $clog2(MW + 1);
  localparam int E_ALL = (1 << ES) - 1;
  localparam logic signed [EW-1:0] EXP_ALL1 = EW'(E_ALL);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  // Valid/ready: a beat moves on valid & ready; every stage advances together
  // whenever the output slot is empty or being drained, otherwise all hold.
  logic w_adv;
  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv;

  logic [ES-1:0] w_a_exp, w_b_exp, w_big_exp, w_sml_exp;
  logic [MS-1:0] w_a_frac, w_b_frac, w_big_frac, w_sml_frac;
  logic          w_a_sign, w_b_sign, w_big_sign, w_sml_sign, w_a_big, w_lost;
  fp_class_e     w_a_cls, w_b_cls;
  int unsigned   w_shift;
  logic [MW-1:0] w_sml_ext, w_sml_sh, w_sml_algn;

  assign w_a_exp  = ES'(fp_exp(64'(a), ES, MS));
  assign w_b_exp  = ES'(fp_exp(64'(b), ES, MS));
  assign w_a_frac = MS'(fp_frac(64'(a), MS));
  assign w_b_frac = MS'(fp_frac(64'(b), MS));
  assign w_a_sign = fp_sign(64'(a), ES, MS);
  assign w_b_sign = fp_sign(64'(b), ES, MS) ^ ~mode;
  assign w_a_cls  = fp_classify(64'(w_a_exp), 64'(w_a_frac), ES);
  assign w_b_cls  = fp_classify(64'(w_b_exp), 64'(w_b_frac), ES);

  always_comb begin
    w_a_big = {w_a_exp, w_a_frac} >= {w_b_exp, w_b_frac};
    if (w_a_big) begin
      w_big_exp = w_a_exp; w_big_frac = w_a_frac; w_big_sign = w_a_sign;
      w_sml_exp = w_b_exp; w_sml_frac = w_b_frac; w_sml_sign = w_b_sign;
    end else begin
      w_big_exp = w_b_exp; w_big_frac = w_b_frac; w_big_sign = w_b_sign;
      w_sml_exp = w_a_exp; w_sml_frac = w_a_frac; w_sml_sign = w_a_sign;
    end
    // Shifts beyond the full significand only contribute to sticky.
    w_shift = 32'(w_big_exp - w_sml_exp);
    if (w_shift > unsigned'(MW)) w_shift = unsigned'(MW);
    w_sml_ext = {1'b1, w_sml_frac, 3'b000};
    w_sml_sh  = w_sml_ext >> w_shift;
    w_lost    = 1'b0;
    for (int i = 0; i < MW; i++) begin
      if (unsigned'(i) < w_shift) w_lost = w_lost | w_sml_ext[i];
    end
    w_sml_algn = {w_sml_sh[MW-1:1], w_sml_sh[0] | w_lost};
  end

  logic             w_spec;
  logic [WIDTH-1:0] w_spec_val;
  logic [3:0]       w_spec_flags;

  always_comb begin
    w_spec       = 1'b1;
    w_spec_val   = '0;
    w_spec_flags = '0;
    if (w_a_cls == FP_NAN || w_b_cls == FP_NAN ||
        (w_a_cls == FP_INF && w_b_cls == FP_INF && w_a_sign != w_b_sign)) begin
      w_spec_val                 = WIDTH'(fp_qnan(ES, MS));
      w_spec_flags[FLAG_INVALID] = 1'b1;
    end else if (w_a_cls == FP_INF) begin
      w_spec_val = a;
    end else if (w_b_cls == FP_INF) begin
      w_spec_val = {w_b_sign, w_b_exp, w_b_frac};
    end else if (w_a_cls == FP_ZERO && w_b_cls == FP_ZERO) begin
      w_spec_val = {w_a_sign & w_b_sign, {(ES + MS){1'b0}}};
    end else if (w_a_cls == FP_ZERO) begin
      w_spec_val = {w_b_sign, w_b_exp, w_b_frac};
    end else if (w_b_cls == FP_ZERO) begin
      w_spec_val = a;
    end else begin
      w_spec = 1'b0;
    end
  end

  logic                    r_s1_valid, r_s1_spec, r_s1_sign, r_s1_sub;
  logic [WIDTH-1:0]        r_s1_spec_val;
  logic [3:0]              r_s1_spec_flags;
  logic signed [EW-1:0]    r_s1_exp;
  logic [MW-1:0]           r_s1_big, r_s1_sml;
  logic                    r_s2_valid, r_s2_spec, r_s2_sign;
  logic [WIDTH-1:0]        r_s2_spec_val;
  logic [3:0]              r_s2_spec_flags;
  logic signed [EW-1:0]    r_s2_exp;
  logic [SW-1:0]           r_s2_sum;
  logic                    r_s3_valid, r_s3_spec, r_s3_sign;
  logic [WIDTH-1:0]        r_s3_spec_val;
  logic [3:0]              r_s3_spec_flags;
  logic signed [EW-1:0]    r_s3_exp;
  logic [MW-1:0]           r_s3_mant;
  logic                    r_s4_valid;
  logic [WIDTH-1:0]        r_out;
  logic [3:0]              r_flags;

  // Swap guarantees big >= small, so the difference never goes negative.
  logic [SW-1:0] w_sum;
  assign w_sum = r_s1_sub ? ({1'b0, r_s1_big} - {1'b0, r_s1_sml})
                          : ({1'b0, r_s1_big} + {1'b0, r_s1_sml});

  logic [CW-1:0]        w_lzc;
  logic                 w_lzc_zero, w_norm_zero;
  logic [MW-1:0]        w_norm;
  logic signed [EW-1:0] w_norm_exp;

  fp_lzc #(.W(MW)) u_lzc (
    .i_data  (r_s2_sum[MW-1:0]),
    .o_count (w_lzc),
    .o_zero  (w_lzc_zero)
  );

  always_comb begin
    if (r_s2_sum[SW-1]) begin
      w_norm      = {r_s2_sum[SW-1:2], r_s2_sum[1] | r_s2_sum[0]};
      w_norm_exp  = r_s2_exp + EW'(1);
      w_norm_zero = 1'b0;
    end else begin
      w_norm      = r_s2_sum[MW-1:0] << w_lzc;
      w_norm_exp  = r_s2_exp - EW'(w_lzc);
      w_norm_zero = w_lzc_zero;
    end
  end

  // A cleared hidden bit after normalisation marks an exact-zero sum.
  logic                 w_inc;
  logic [MS:0]          w_rnd;
  logic signed [EW-1:0] w_rnd_exp;
  logic [WIDTH-1:0]     w_pk_out;
  logic [3:0]           w_pk_flags;

  always_comb begin
    w_inc      = r_s3_mant[2] & (r_s3_mant[1] | r_s3_mant[0] | r_s3_mant[3]);
    w_rnd      = {1'b0, r_s3_mant[MW-2:3]} + (MS + 1)'(w_inc);
    w_rnd_exp  = r_s3_exp + EW'(w_rnd[MS]);
    w_pk_out   = '0;
    w_pk_flags = '0;
    if (r_s3_spec) begin
      w_pk_out   = r_s3_spec_val;
      w_pk_flags = r_s3_spec_flags;
    end else if (!r_s3_mant[MW-1]) begin
      w_pk_out = '0;
    end else if (w_rnd_exp >= EXP_ALL1) begin
      w_pk_out                    = {r_s3_sign, {ES{1'b1}}, {MS{1'b0}}};
      w_pk_flags[FLAG_OVERFLOW]   = 1'b1;
      w_pk_flags[FLAG_INEXACT]    = 1'b1;
    end else if (w_rnd_exp <= EXP_ZERO) begin
      w_pk_out                    = {r_s3_sign, {(ES + MS){1'b0}}};
      w_pk_flags[FLAG_UNDERFLOW]  = 1'b1;
      w_pk_flags[FLAG_INEXACT]    = 1'b1;
    end else begin
      w_pk_out                    = {r_s3_sign, w_rnd_exp[ES-1:0], w_rnd[MS-1:0]};
      w_pk_flags[FLAG_INEXACT]    = |r_s3_mant[2:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0; r_s1_spec <= 1'b0; r_s1_sign <= 1'b0; r_s1_sub <= 1'b0;
      r_s1_spec_val <= '0; r_s1_spec_flags <= '0; r_s1_exp <= '0;
      r_s1_big <= '0; r_s1_sml <= '0;
      r_s2_valid <= 1'b0; r_s2_spec <= 1'b0; r_s2_sign <= 1'b0;
      r_s2_spec_val <= '0; r_s2_spec_flags <= '0; r_s2_exp <= '0; r_s2_sum <= '0;
      r_s3_valid <= 1'b0; r_s3_spec <= 1'b0; r_s3_sign <= 1'b0;
      r_s3_spec_val <= '0; r_s3_spec_flags <= '0; r_s3_exp <= '0; r_s3_mant <= '0;
      r_s4_valid <= 1'b0; r_out <= '0; r_flags <= '0;
    end else if (w_adv) begin
      r_s1_valid      <= in_valid;
      r_s1_spec       <= w_spec;
      r_s1_spec_val   <= w_spec_val;
      r_s1_spec_flags <= w_spec_flags;
      r_s1_sign       <= w_big_sign;
      r_s1_sub        <= w_big_sign ^ w_sml_sign;
      r_s1_exp        <= {2'b00, w_big_exp};
      r_s1_big        <= {1'b1, w_big_frac, 3'b000};
      r_s1_sml        <= w_sml_algn;

      r_s2_valid      <= r_s1_valid;
      r_s2_spec       <= r_s1_spec;
      r_s2_spec_val   <= r_s1_spec_val;
      r_s2_spec_flags <= r_s1_spec_flags;
      r_s2_sign       <= r_s1_sign;
      r_s2_exp        <= r_s1_exp;
      r_s2_sum        <= w_sum;

      r_s3_valid      <= r_s2_valid;
      r_s3_spec       <= r_s2_spec;
      r_s3_spec_val   <= r_s2_spec_val;
      r_s3_spec_flags <= r_s2_spec_flags;
      r_s3_sign       <= w_norm_zero ? 1'b0 : r_s2_sign;
      r_s3_exp        <= w_norm_exp;
      r_s3_mant       <= w_norm;

      r_s4_valid      <= r_s3_valid;
      r_out           <= w_pk_out;
      r_flags         <= w_pk_flags;
    end
  end

  assign out_valid = r_s4_valid;
  assign out       = r_out;
  assign flags     = r_flags;

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Parametrised, pipelined floating-point add/subtract unit for the CORDIC datapath. It generalises the combinational bfloat adder to any EXP_SIZE/MANTISSA_SIZE and adds a 4-stage pipeline with valid/ready handshake. It also adds leading-zero normalisation after subtraction, round-to-nearest-even and IEEE-style special-value handling. It sits between the CORDIC iteration controller and the angle/vector registers.

Parameters:
EXP_SIZE, 8, exponent field width; bias = 2^(EXP_SIZE-1)-1
MANTISSA_SIZE, 7, stored fraction width (hidden 1 implied)
WIDTH, 1+EXP_SIZE+MANTISSA_SIZE, derived operand width; not overridable

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands a, b and mode valid this cycle
in_ready  out  1  unit accepts operands; equals (~stage4_valid | out_ready)
a  in  WIDTH  operand A {sign, exp, fraction}
b  in  WIDTH  operand B {sign, exp, fraction}
mode  in  1  1 = a+b, 0 = a-b (B sign inverted)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out  out  WIDTH  rounded result
flags  out  4  {invalid, overflow, underflow, inexact} for the result on out

Behaviour:
- Reset (async, rst=1): all stage valid bits, out_valid, out and flags go to 0 immediately. in_ready is combinational and reads 1 during reset. Reset mid-operation discards all in-flight operations.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - The whole pipeline advances together when in_ready=1 and holds when in_ready=0.
  - out and flags stay stable while out_valid=1 & out_ready=0.
  - Latency is exactly 4 cycles with no stall. Throughput is 1 result per cycle.
- Operand classification:
  - exp==0 is zero; denormals are flushed to signed zero.
  - exp==all-ones with fraction==0 is inf.
  - exp==all-ones with fraction!=0 is NaN.
- S1 align:
  - Effective B sign = b_sign ^ ~mode.
  - Swap operands so the larger magnitude (exp, then fraction) is "big".
  - Prepend the hidden 1 and extend by 3 bits: guard, round, sticky.
  - Right-shift the small operand by the exponent difference. Shift bits are ORed into sticky. A difference >= MANTISSA_SIZE+3 leaves only sticky.
- S2 add:
  - Same effective signs: add with 1 carry bit.
  - Different signs: big - small, which is never negative after the swap.
  - Result sign = big sign.
- S3 normalise:
  - Carry out: shift right 1 (sticky preserved) and exp+1.
  - Otherwise use fp_lzc to find the leading-zero count L. Shift left L and exp-L.
  - Exact zero sum gives +0 (the sign is forced to 0 even for -x + x).
- S4 round/pack:
  - Round to nearest even: increment when G & (R | S | lsb).
  - Mantissa overflow from rounding: exp+1 and fraction 0.
  - inexact = G|R|S.
  - exp >= all-ones: out = signed inf, overflow=1, inexact=1.
  - exp <= 0: out = signed zero, underflow=1, inexact=1.
- Special precedence (resolved in S1, carried as a bypass tag; datapath result is ignored):
  - NaN input, or inf-inf with opposite effective signs: out = canonical qNaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - Single inf: out = that inf with its effective sign.
  - Zero operand: the other operand passes through exactly. For 0 +/- 0, sign = AND of both effective signs.
- Width rules: internal exponent is EXP_SIZE+2 bits signed, to catch overflow and underflow. The significand path is MANTISSA_SIZE+5 bits (carry, hidden bit, fraction, G, R, S).

Decomposition:
- Package fp_pkg:
  - localparams EXP_SIZE, MANTISSA_SIZE, BIAS, EXP_MAX.
  - class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}.
  - functions fp_exp, fp_frac, fp_sign, fp_qnan.
  - flag bit indices.
- One sub-module fp_lzc: parametrised combinational leading-zero counter (width in, count out, all-zero flag), instantiated in S3. Reusable by the CORDIC normaliser.

Test Plan:
- Add, default params, mode=1: a=0x3F80 (1.0), b=0x4000 (2.0) -> out=0x4040 after 4 cycles, flags=0.
- Subtract with normalise, mode=0: a=0x3FC0 (1.5), b=0x3F80 -> out=0x3F00 (0.5); then a=b=0x3F80 -> out=0x0000.
- RNE ties, mode=1: 0x3F80 + 0x3B80 (2^-8) -> 0x3F80, inexact=1; 0x3F81 + 0x3B80 -> 0x3F82, inexact=1.
- Specials:
  - 0x7F7F + 0x7F7F -> 0x7F80, overflow=1, inexact=1.
  - 0x7F80 - 0x7F80 -> 0x7FC0, invalid=1.
  - 0xFF80 + 0x3F80 -> 0xFF80.
- Backpressure: stream 8 back-to-back ops and hold out_ready=0 for 5 cycles mid-stream -> in_ready drops, no result lost or duplicated, results arrive in order and stay stable while stalled.
- Reset mid-flight: assert rst asynchronously (between edges) with 3 ops in flight -> out_valid=0 immediately; after release, the next op's result appears 4 cycles after acceptance.
